// File: rtl/seq_det_ctrl_if.sv
// Bus bundle for seq_det_ctrl: configuration writes, run control, symbol stream and status.
// master drives commands and the stream; slave is the detector.
interface seq_det_ctrl_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) ();
  logic                         cfg_we;
  logic [$clog2(DEPTH)-1:0]     cfg_addr;
  logic [1:0]                   cfg_sym;
  logic                         cfg_len_we;
  logic [$clog2(DEPTH+1)-1:0]   cfg_len;
  logic                         start;
  logic                         stop;
  logic                         i1;
  logic                         i2;
  logic                         o;
  logic                         busy;
  logic [CNT_W-1:0]             match_cnt;
  logic                         err;

  modport master (
    output cfg_we, cfg_addr, cfg_sym, cfg_len_we, cfg_len, start, stop, i1, i2,
    input  o, busy, match_cnt, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sym, cfg_len_we, cfg_len, start, stop, i1, i2,
    output o, busy, match_cnt, err
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Programmable 2-input sequence detector: loadable pattern of up to DEPTH symbols,
// start/stop arming, non-overlapping match pulses and a saturating match counter.
module seq_det_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  seq_det_ctrl_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned LenW = $clog2(DEPTH + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [LenW-1:0] len_q, len_d;
  logic [1:0]      sym_q [DEPTH];
  logic [1:0]      sym_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            o_q, o_d;
  logic            err_q, err_d;

  logic [1:0] s;
  logic       len_ok;
  logic       last;

  assign s       = {bus.i1, bus.i2};
  assign len_ok  = (int'(len_q) >= 2) && (int'(len_q) <= int'(DEPTH));
  assign last    = (int'(idx_q) == int'(len_q) - 1);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    o_d     = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cfg_we && (int'(bus.cfg_addr) < int'(DEPTH))) begin
          sym_d[bus.cfg_addr] = bus.cfg_sym;
        end
        if (bus.cfg_len_we) begin
          len_d = bus.cfg_len;
        end
        // stop dominates start; legality is judged on the length already stored
        if (bus.start && !bus.stop) begin
          if (len_ok) begin
            state_d = StRun;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (bus.cfg_we || bus.cfg_len_we) begin
          err_d = 1'b1;
        end
        if (bus.stop) begin
          state_d = StIdle;
        end else if (s == sym_q[idx_q]) begin
          if (last) begin
            o_d   = 1'b1;
            idx_d = '0;
            cnt_d = cnt_inc;
            // counter reaching all-ones ends the run so it never wraps
            if (&cnt_inc) begin
              state_d = StIdle;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          idx_d = (s == sym_q[0]) ? IdxW'(1) : '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      sym_q   <= '{default: 2'b00};
      cnt_q   <= '0;
      o_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      err_q   <= err_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.match_cnt = cnt_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scenario bench for seq_det_ctrl: a wide-counter instance for detection and command checks,
// and a CNT_W=2 instance for saturation.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // {o, busy} expected per stream sample, and what the DUT showed after that edge
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  seq_det_ctrl_if #(.DEPTH(4), .CNT_W(8)) m  ();
  seq_det_ctrl_if #(.DEPTH(4), .CNT_W(2)) sd ();

  seq_det_ctrl #(.DEPTH(4), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(m));
  seq_det_ctrl #(.DEPTH(4), .CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(sd));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [1:0] exp, input bit on_s);
    m.i1  = s[1];
    m.i2  = s[0];
    sd.i1 = s[1];
    sd.i2 = s[0];
    exp_q.push_back(exp);
    tick;
    obs_q.push_back(on_s ? {sd.o, sd.busy} : {m.o, m.busy});
  endtask

  task automatic prog(input bit on_s, input logic [7:0] pat, input int len);
    for (int k = 0; k < 4; k++) begin
      if (on_s) begin
        sd.cfg_we = 1'b1; sd.cfg_addr = 2'(k); sd.cfg_sym = pat[7-2*k -: 2];
        sd.cfg_len_we = (k == 3); sd.cfg_len = 3'(len);
      end else begin
        m.cfg_we = 1'b1; m.cfg_addr = 2'(k); m.cfg_sym = pat[7-2*k -: 2];
        m.cfg_len_we = (k == 3); m.cfg_len = 3'(len);
      end
      tick;
    end
    m.cfg_we = 1'b0; m.cfg_len_we = 1'b0;
    sd.cfg_we = 1'b0; sd.cfg_len_we = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_total++;
    if ({m.o, m.busy, m.match_cnt, m.err} !== 11'd0) begin
      $display("FAIL reset_main: got o/busy/cnt/err=%b want 0", {m.o, m.busy, m.match_cnt, m.err});
    end else n_pass++;
    n_total++;
    if ({sd.o, sd.busy, sd.match_cnt, sd.err} !== 5'd0) begin
      $display("FAIL reset_sat: got o/busy/cnt/err=%b want 0", {sd.o, sd.busy, sd.match_cnt, sd.err});
    end else n_pass++;
    #2 rst = 1'b1;
    tick;
  endtask

  task automatic test_basic_match;
    logic [7:0] pat;
    logic [1:0] e, a;
    pat = 8'b00_11_00_01;
    prog(1'b0, pat, 4);
    m.start = 1'b1; tick; m.start = 1'b0;
    n_total++;
    if ({m.busy, m.err, m.match_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      $display("FAIL basic_start: got busy/err/cnt=%b want 1_0_0", {m.busy, m.err, m.match_cnt});
    end else n_pass++;
    for (int k = 0; k < 4; k++) send(pat[7-2*k -: 2], {k == 3, 1'b1}, 1'b0);
    send(2'b10, 2'b01, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL basic_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    n_total++;
    if ({m.busy, m.match_cnt} !== {1'b1, 8'd1}) begin
      $display("FAIL basic_cnt: got busy/cnt=%b want 1_00000001", {m.busy, m.match_cnt});
    end else n_pass++;
  endtask

  task automatic test_restart;
    logic [1:0] sa [5];
    logic [1:0] sb [7];
    logic [1:0] e, a;
    sa = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b01};
    sb = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01};
    m.stop = 1'b1; tick; m.stop = 1'b0;
    m.start = 1'b1; tick; m.start = 1'b0;
    for (int k = 0; k < 5; k++) send(sa[k], {k == 4, 1'b1}, 1'b0);
    n_total++;
    if (m.match_cnt !== 8'd1) $display("FAIL restart_cnt_a: got %0d want 1", m.match_cnt);
    else n_pass++;
    for (int k = 0; k < 7; k++) send(sb[k], {k == 6, 1'b1}, 1'b0);
    send(2'b10, 2'b01, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL restart_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    n_total++;
    if (m.match_cnt !== 8'd2) $display("FAIL restart_cnt_b: got %0d want 2", m.match_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal_cmd;
    logic [7:0] pat;
    logic [1:0] e, a;
    pat = 8'b00_11_00_01;
    m.stop = 1'b1; tick; m.stop = 1'b0;
    m.cfg_len_we = 1'b1; m.cfg_len = 3'd1; tick; m.cfg_len_we = 1'b0;
    m.start = 1'b1; tick; m.start = 1'b0;
    n_total++;
    if ({m.err, m.busy} !== 2'b10) $display("FAIL badlen_err: got err/busy=%b want 10", {m.err, m.busy});
    else n_pass++;
    tick;
    n_total++;
    if (m.err !== 1'b0) $display("FAIL badlen_pulse: got err=%b want 0", m.err);
    else n_pass++;
    m.cfg_len_we = 1'b1; m.cfg_len = 3'd4; tick; m.cfg_len_we = 1'b0;
    m.start = 1'b1; tick; m.start = 1'b0;
    n_total++;
    if ({m.err, m.busy} !== 2'b01) $display("FAIL goodlen: got err/busy=%b want 01", {m.err, m.busy});
    else n_pass++;
    m.cfg_we = 1'b1; m.cfg_addr = 2'd1; m.cfg_sym = 2'b10; m.i1 = 1'b1; m.i2 = 1'b0;
    tick;
    m.cfg_we = 1'b0;
    n_total++;
    if ({m.err, m.busy} !== 2'b11) $display("FAIL runwrite_err: got err/busy=%b want 11", {m.err, m.busy});
    else n_pass++;
    for (int k = 0; k < 4; k++) send(pat[7-2*k -: 2], {k == 3, 1'b1}, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL runwrite_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    n_total++;
    if (m.match_cnt !== 8'd1) $display("FAIL runwrite_cnt: got %0d want 1", m.match_cnt);
    else n_pass++;
    m.stop = 1'b1; tick; m.stop = 1'b0;
  endtask

  task automatic test_saturation;
    logic [7:0] pat;
    logic [1:0] e, a;
    pat = 8'b00_11_00_01;
    prog(1'b1, pat, 4);
    sd.start = 1'b1; tick; sd.start = 1'b0;
    n_total++;
    if (sd.busy !== 1'b1) $display("FAIL sat_start: got busy=%b want 1", sd.busy);
    else n_pass++;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (r < 2)       send(pat[7-2*k -: 2], {k == 3, 1'b1}, 1'b1);
        else if (r == 2) send(pat[7-2*k -: 2], {k == 3, k != 3}, 1'b1);
        else             send(pat[7-2*k -: 2], 2'b00, 1'b1);
      end
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL sat_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    n_total++;
    if ({sd.match_cnt, sd.err} !== 3'b110) begin
      $display("FAIL sat_cnt: got cnt/err=%b want 11_0", {sd.match_cnt, sd.err});
    end else n_pass++;
  endtask

  task automatic test_reset_midrun;
    logic [7:0] pat;
    logic [1:0] e, a;
    pat = 8'b00_11_00_01;
    m.start = 1'b1; tick; m.start = 1'b0;
    for (int k = 0; k < 4; k++) send(pat[7-2*k -: 2], {k == 3, 1'b1}, 1'b0);
    send(2'b00, 2'b01, 1'b0);
    send(2'b11, 2'b01, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL midrun_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    n_total++;
    if (m.match_cnt !== 8'd1) $display("FAIL midrun_pre: got cnt=%0d want 1", m.match_cnt);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({m.o, m.busy, m.match_cnt} !== 10'd0) begin
      $display("FAIL midrun_rst: got o/busy/cnt=%b want 0", {m.o, m.busy, m.match_cnt});
    end else n_pass++;
    #2 rst = 1'b1;
    m.start = 1'b1; tick; m.start = 1'b0;
    n_total++;
    if ({m.err, m.busy} !== 2'b10) $display("FAIL midrun_len0: got err/busy=%b want 10", {m.err, m.busy});
    else n_pass++;
  endtask

  task automatic test_start_stop;
    logic [7:0] pat;
    logic [1:0] e, a;
    pat = 8'b00_11_00_01;
    prog(1'b0, pat, 4);
    m.start = 1'b1; tick; m.start = 1'b0;
    for (int k = 0; k < 4; k++) send(pat[7-2*k -: 2], {k == 3, 1'b1}, 1'b0);
    for (int k = 0; k < 3; k++) send(pat[7-2*k -: 2], 2'b01, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); a = obs_q.pop_front(); n_total++;
      if (a !== e) $display("FAIL ss_seq[%0d]: got o/busy=%b want %b", k, a, e);
      else n_pass++;
    end
    m.start = 1'b1; m.stop = 1'b1; m.i1 = 1'b0; m.i2 = 1'b1;
    tick;
    m.start = 1'b0; m.stop = 1'b0;
    n_total++;
    if ({m.o, m.busy, m.err, m.match_cnt} !== {3'b000, 8'd1}) begin
      $display("FAIL ss_edge: got o/busy/err/cnt=%b want 000_00000001",
               {m.o, m.busy, m.err, m.match_cnt});
    end else n_pass++;
    tick;
    n_total++;
    if ({m.o, m.busy} !== 2'b00) $display("FAIL ss_after: got o/busy=%b want 00", {m.o, m.busy});
    else n_pass++;
  endtask

  initial begin
    {m.cfg_we, m.cfg_addr, m.cfg_sym, m.cfg_len_we, m.cfg_len, m.start, m.stop, m.i1, m.i2} = '0;
    {sd.cfg_we, sd.cfg_addr, sd.cfg_sym, sd.cfg_len_we, sd.cfg_len, sd.start, sd.stop, sd.i1,
     sd.i2} = '0;
    test_reset;
    test_basic_match;
    test_restart;
    test_illegal_cmd;
    test_saturation;
    test_reset_midrun;
    test_start_stop;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
